// File: rtl/gate_stim_checker.sv
// Exhaustive stimulus generator and response checker for a small
// combinational gate: walks every input vector in ascending order, samples
// the gate output after a programmable settle time and compares it against
// a truth table, reporting pass/fail, the error count and the first failing vector.
module gate_stim_checker #(
    parameter int unsigned         N_IN          = 2,
    parameter int unsigned         SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT        = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] stim,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned CW    = 4;
    localparam int unsigned EW    = N_IN + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] fvec_q, fvec_d;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    // Next-state and next-output logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_DRIVE;
                    busy_d  = 1'b1;
                    vec_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                stim_d  = vec_q;
                cnt_d   = CW'(SETTLE_CYCLES);
                state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_SAMPLE;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (y != EXPECT[vec_q]) begin
                    err_d = err_q + EW'(1);
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q == N_IN'(N_VEC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards whatever the current state decided, including a compare.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            vec_d   = vec_q;
            cnt_d   = cnt_q;
            stim_d  = stim_q;
            pass_d  = pass_q;
            err_d   = err_q;
            fv_d    = fv_q;
            fvec_d  = fvec_q;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: default-settle instance drives a
// selectable gate model; two more instances cover settle times of 0 and 3.
module tb_gate_stim_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // main instance (SETTLE_CYCLES = 1), gate mode: 0 = AND, 1 = OR, 2 = stuck-0
    int        mode = 0;
    logic      start = 1'b0, abort = 1'b0;
    logic [1:0] stim;
    logic      y;
    logic      busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] fail_vec;

    assign y = (mode == 0) ? (stim[1] & stim[0]) :
               (mode == 1) ? (stim[1] | stim[0]) : 1'b0;

    gate_stim_checker #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECT(4'b1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim),
        .y(y), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    // SETTLE_CYCLES = 0 instance, ideal AND
    logic      start0 = 1'b0;
    logic [1:0] stim0, fvec0;
    logic      busy0, done0, pass0, fv0;
    logic [2:0] err0;

    gate_stim_checker #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECT(4'b1000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .stim(stim0),
        .y(stim0[1] & stim0[0]), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
    );

    // SETTLE_CYCLES = 3 instance, ideal AND
    logic      start3 = 1'b0;
    logic [1:0] stim3, fvec3;
    logic      busy3, done3, pass3, fv3;
    logic [2:0] err3;

    gate_stim_checker #(.N_IN(2), .SETTLE_CYCLES(3), .EXPECT(4'b1000)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .stim(stim3),
        .y(stim3[1] & stim3[0]), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .fail_vec(fvec3)
    );

    logic [1:0] hist [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on one instance, then count cycles from the accept edge to done.
    task automatic sweep(input int which, output int cyc, output logic busy_acc);
        logic d;
        @(negedge clk);
        if (which == 0) start = 1'b1; else if (which == 1) start0 = 1'b1; else start3 = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start0 = 1'b0; start3 = 1'b0;
        busy_acc = (which == 0) ? busy : (which == 1) ? busy0 : busy3;
        cyc = 0;
        while (cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < 64) hist[cyc] = (which == 0) ? stim : (which == 1) ? stim0 : stim3;
            d = (which == 0) ? done : (which == 1) ? done0 : done3;
            if (d) break;
        end
    endtask

    int   cyc;
    logic bacc;
    logic saw_done;

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {stim, busy, done, pass, err_count, fail_valid, fail_vec},
            32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ideal AND sweep
        mode = 0;
        sweep(0, cyc, bacc);
        chk("and_busy_accept", 32'(bacc), 32'd1);
        chk("and_latency", 32'(cyc), 32'd13);
        for (int k = 1; k <= 12; k++) chk("and_stim_walk", 32'(hist[k]), 32'((k - 1) / 3));
        chk("and_pass", 32'(pass), 32'd1);
        chk("and_err", 32'(err_count), 32'd0);
        chk("and_fv", 32'(fail_valid), 32'd0);
        chk("and_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("stim_held", 32'(stim), 32'd3);
        chk("pass_held", 32'(pass), 32'd1);

        // OR gate on the checker
        mode = 1;
        sweep(0, cyc, bacc);
        chk("or_latency", 32'(cyc), 32'd13);
        chk("or_err", 32'(err_count), 32'd2);
        chk("or_fv", 32'(fail_valid), 32'd1);
        chk("or_fvec", 32'(fail_vec), 32'd1);
        chk("or_pass", 32'(pass), 32'd0);

        // stuck-at-0 output
        mode = 2;
        sweep(0, cyc, bacc);
        chk("s0_err", 32'(err_count), 32'd1);
        chk("s0_fvec", 32'(fail_vec), 32'd3);
        chk("s0_pass", 32'(pass), 32'd0);

        // rerun ideal: counters cleared at accept
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("rerun_err_cleared", 32'(err_count), 32'd0);
        chk("rerun_fv_cleared", 32'(fail_valid), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 20 && !saw_done; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("rerun_done", 32'(saw_done), 32'd1);
        chk("rerun_pass", 32'(pass), 32'd1);

        // settle 0 and settle 3 instances
        sweep(1, cyc, bacc);
        chk("s0c_latency", 32'(cyc), 32'd9);
        chk("s0c_stim_v1", 32'(hist[3]), 32'd1);
        chk("s0c_stim_v1b", 32'(hist[4]), 32'd1);
        chk("s0c_pass", 32'(pass0), 32'd1);
        sweep(2, cyc, bacc);
        chk("s3c_latency", 32'(cyc), 32'd21);
        chk("s3c_pass", 32'(pass3), 32'd1);

        // second start while busy is ignored; abort during vector 2 SETTLE
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;           // accept edge E0
        repeat (2) @(posedge clk);
        #1; start = 1'b1;                           // extra start, busy
        repeat (5) @(posedge clk);                  // now after E7: vec 2 SETTLE
        #1; start = 1'b0;
        chk("ab_stim_before", 32'(stim), 32'd2);
        chk("ab_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_stim_held", 32'(stim), 32'd2);
        chk("ab_err_partial", 32'(err_count), 32'd1);
        chk("ab_fvec_partial", 32'(fail_vec), 32'd1);
        chk("ab_pass", 32'(pass), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("ab_no_done", 32'(saw_done), 32'd0);
        chk("ab_stim_idle", 32'(stim), 32'd2);

        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("start_abort_stim", 32'(stim), 32'd2);

        // reset during vector 1 SAMPLE
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rs_stim_before", 32'(stim), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_outputs", {stim, busy, done, pass, err_count, fail_valid, fail_vec},
            32'h0);
        @(negedge clk); rst_n = 1'b1;
        mode = 0;
        sweep(0, cyc, bacc);
        chk("rs_latency", 32'(cyc), 32'd13);
        chk("rs_pass", 32'(pass), 32'd1);
        chk("rs_err", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
- Exhaustive stimulus generator and response checker for a combinational gate under test.
- Sits directly upstream of the gate: drives its inputs with every input vector in ascending order.
- Samples the gate output after a programmable settle time and compares it against a parameterised truth table.
- Reports busy/done, pass/fail, error count and first failing vector; replaces hand-written #delay/$display benches for the 2-input gate family.

Parameters:
- N_IN, 2, number of gate inputs; vectors 0 .. 2**N_IN-1.
- SETTLE_CYCLES, 1, cycles between driving a vector and sampling y (legal range 0..15).
- EXPECT, 4'b1000, expected-output truth table, width 2**N_IN; bit i = expected y for vector i (default = AND).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE, no done pulse.
- stim  output  N_IN  registered vector to gate; stim[N_IN-1] = a, stim[0] = b for 2 inputs.
- y  input  1  gate output under test.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  valid at done; high iff err_count == 0; held until next accepted start.
- err_count  output  N_IN+1  mismatches in current/last sweep; cannot overflow.
- fail_valid  output  1  a mismatch has been recorded this sweep.
- fail_vec  output  N_IN  first mismatching vector; valid when fail_valid.

Behaviour:
- Reset (async assert, sync release): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, vec=0, settle counter=0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE; clear err_count, fail_valid, fail_vec, pass; vec=0.
  - start is ignored in every other state.
- DRIVE (1 cycle): stim<=vec; settle counter<=SETTLE_CYCLES. Next state is SETTLE, or SAMPLE if SETTLE_CYCLES==0.
- SETTLE: decrement counter each cycle; -> SAMPLE when the counter reaches 1. Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): compare y with EXPECT[vec].
  - On mismatch: err_count+1; if fail_valid==0, set fail_valid=1 and fail_vec=vec.
  - If vec==2**N_IN-1 -> DONE; else vec+1 -> DRIVE.
  - No wrap: the sweep ends on the last vector.
- DONE (1 cycle): done=1; pass=(err_count==0), using the count after the final SAMPLE update; busy=0 on the next cycle; -> IDLE.
- Per-vector cost: 2+SETTLE_CYCLES cycles. Full sweep from the start-accept edge to the done pulse: 2**N_IN*(2+SETTLE_CYCLES)+1 cycles (13 for the defaults).
- stim holds its last value after the sweep and in IDLE; it is not returned to 0 except by reset.
- abort=1 in any non-IDLE state:
  - -> IDLE next cycle; busy=0; done stays 0.
  - err_count/fail_* keep their partial values; pass stays 0.
  - abort has priority over every other transition, including the SAMPLE compare in the same cycle (that compare is discarded).
- abort and start both high in IDLE: abort wins; start is ignored.
- rst_n asserted mid-sweep: all outputs return to reset values immediately, with no done pulse.
- y is sampled only in SAMPLE; y changes in other cycles have no effect. X/Z on y is unspecified (2-state compare).

Test Plan:
- Defaults, ideal AND gate on stim, start pulse -> stim walks 00,01,10,11, each held 3 cycles; done pulses 13 cycles after start accepted; pass=1, err_count=0, fail_valid=0.
- y tied to OR of stim, defaults -> err_count=2 (vectors 01,10), fail_valid=1, fail_vec=2'b01, pass=0.
- y stuck at 0 -> err_count=1, fail_vec=2'b11, pass=0; then rerun with ideal AND -> err_count cleared on start, pass=1.
- SETTLE_CYCLES=0, ideal AND -> each vector held 2 cycles, done 9 cycles after start; SETTLE_CYCLES=3 -> done 21 cycles after start.
- Pulse start again while busy; assert abort during vector 2's SETTLE -> second start ignored; after abort, IDLE next cycle, done never pulses, busy=0, stim=2'b10 held.
- Drop rst_n low during vector 1's SAMPLE -> all outputs 0 immediately; after release, start yields a clean 13-cycle sweep with pass=1.
